encoder32to5_drain: RTL
=======================

# encoder32to5_drain

Sequential 32-to-5 encoder, the inverse of the 5-to-32 decoder. It accepts a 32-bit multi-hot vector and emits the 5-bit index of every set bit, one index per handshake, in priority order. It sits between a request/flag vector producer and any consumer that needs binary indices, such as a register-select stage feeding the decoder.

## Interface
- `MSB_FIRST`, default 0: 0 = emit lowest set index first; 1 = emit highest set index first.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  `in_vec` is valid this cycle.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_vec`  in  32  multi-hot input vector; bit i set means index i is pending.
- `out_valid`  out  1  `out_idx` holds a valid index.
- `out_ready`  in  1  consumer accepts `out_idx` this cycle.
- `out_idx`  out  5  current priority index.
- `out_seq`  out  5  0-based ordinal of `out_idx` within the current vector.
- `out_last`  out  1  current index is the final set bit of the vector.
- `zero_pulse`  out  1  one-cycle pulse when an all-zero vector was accepted.

## Operation
- State is a 32-bit `pending` register, a 5-bit `seq` counter, and a 2-state FSM: IDLE and DRAIN.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&&`in_ready` with a nonzero `in_vec`: `pending`<=`in_vec`, `seq`<=0, go to DRAIN.
  - On `in_valid`&&`in_ready` with `in_vec`==0: stay in IDLE, `pending` is unchanged, and `zero_pulse`<=1 for exactly the next cycle.
- DRAIN:
  - `in_ready`=0, `out_valid`=1.
  - `out_idx` is the priority encode of `pending`. With MSB_FIRST=0 it is the lowest set bit; with MSB_FIRST=1 it is the highest set bit.
  - `out_last`=1 when exactly one bit of `pending` is set.
  - `out_seq`=`seq`.
- Transfer happens on `out_valid`&&`out_ready`:
  - Clear bit `out_idx` in `pending`.
  - `seq`<=`seq`+1.
  - If `out_last`, go to IDLE and set `seq`<=0.
- While `out_ready`=0, `out_idx`, `out_seq` and `out_last` must hold stable.
- `in_vec` is ignored whenever `in_ready`=0.
- All outputs are functions of registered state only; there is no combinational path from `in_*` to `out_*`.
- The `seq` counter wraps 31->0 only conceptually. At most 32 transfers occur per vector, so `out_seq`=31 occurs only for `in_vec`=0xFFFFFFFF.

## Timing
- Reset values: FSM=IDLE, `pending`=0, `seq`=0, `in_ready`=1, `out_valid`=0, `out_idx`=0, `out_seq`=0, `out_last`=0, `zero_pulse`=0.
- Reset asserted mid-DRAIN aborts the vector immediately and asynchronously, and all outputs take their reset values. No index is emitted after reset deasserts until a new vector is accepted.
- Latency: a vector accepted at edge N gives `out_valid`=1 in the cycle after edge N.
- Throughput: one index per cycle while `out_ready` is held high. A vector with k set bits drains in k cycles.
- Handoff between vectors:
  - The final transfer at edge M returns the FSM to IDLE, so `in_ready`=1 in the cycle after edge M.
  - The earliest next acceptance is edge M+1, giving a one-cycle bubble between vectors.
- `zero_pulse` is high for one cycle following the accepting edge. Two consecutive zero vectors give two separate one-cycle pulses.

## Test plan
- Reset then idle: assert `rst` while `clk` is running -> all outputs at their reset values, `in_ready`=1.
- MSB_FIRST=0, `in_vec`=0x80000005, `out_ready` held 1:
  - -> `out_idx` 0, 2, 31 on consecutive cycles.
  - -> `out_seq` 0, 1, 2.
  - -> `out_last` asserted only with index 31.
  - -> `in_ready` returns one cycle after the last transfer.
- Backpressure: `in_vec`=0x00000110 with `out_ready` toggling 0,1,0,0,1:
  - -> `out_idx` holds 4 through the stall.
  - -> `out_idx` then moves to 8 with `out_last`=1.
  - -> exactly 2 transfers occur.
- MSB_FIRST=1 with `in_vec`=0xFFFFFFFF:
  - -> 32 transfers, `out_idx` counting 31 down to 0 while `out_seq` counts 0 to 31.
  - -> `out_last` set only on index 0.
- Zero vector: accept `in_vec`=0 -> `zero_pulse`=1 for one cycle, `out_valid` stays 0, FSM stays IDLE.
- Reset mid-operation: accept 0x0000F000, consume one index, then assert `rst` -> `out_valid`=0 immediately. After release, no residual indices appear, and a new vector 0x1 yields a single `out_idx`=0 with `out_last`=1.

Source files
------------

// File: rtl/encoder32to5_drain.sv
// Sequential 32-to-5 encoder: drains every set bit of an accepted vector as one index per handshake.
// Latency: first index valid the cycle after acceptance. Backpressure: output fields hold while out_ready is low, and no new vector is taken until the last index is transferred.
module encoder32to5_drain #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [4:0]  out_seq,
    output logic        out_last,
    output logic        zero_pulse
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pending;
    logic [4:0]  seq;
    logic [4:0]  enc_idx;
    logic        one_left;

    // Later loop iterations win, so the scan direction picks the priority end.
    always_comb begin
        enc_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 32; i++) begin
                if (pending[i]) enc_idx = 5'(i);
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (pending[i]) enc_idx = 5'(i);
            end
        end
    end

    assign one_left   = (pending != 32'd0) && ((pending & (pending - 32'd1)) == 32'd0);

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DRAIN);
    assign out_idx    = enc_idx;
    assign out_seq    = seq;
    assign out_last   = one_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            seq        <= '0;
            zero_pulse <= 1'b0;
        end else begin
            zero_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec == 32'd0) begin
                            zero_pulse <= 1'b1;
                        end else begin
                            pending <= in_vec;
                            seq     <= '0;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        pending <= pending & ~(32'd1 << enc_idx);
                        if (one_left) begin
                            seq   <= '0;
                            state <= IDLE;
                        end else begin
                            seq   <= seq + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
